// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared encodings and default widths for the SDF FFT cascade.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_BF   = 2'd1;
  localparam logic [1:0] ST_TW   = 2'd2;
  localparam logic [1:0] ST_RSVD = 2'd3;

  localparam int DW_DEFAULT      = 24;
  localparam int TW_FRAC_DEFAULT = 8;
  localparam int CMUL_W          = 2 * DW_DEFAULT;

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_BF   = 2'd1,
    OP_TW   = 2'd2
  } op_e;

  // The reserved code behaves exactly like FILL.
  function automatic op_e decode_state(input logic [1:0] st);
    case (st)
      ST_BF:   return OP_BF;
      ST_TW:   return OP_TW;
      default: return OP_FILL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdf_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : sdf_delay_line
// Description : DELAY-deep circular buffer, read-before-write at one pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_delay_line #(
  parameter int DELAY = 64,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int c_aw = (DELAY > 1) ? $clog2(DELAY) : 1;

  logic [WIDTH-1:0] r_mem [DELAY];
  logic [c_aw-1:0]  r_ptr;

  // Combinational read returns the word about to be overwritten this cycle.
  assign rd_data = r_mem[r_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (en) begin
      r_ptr <= (r_ptr == c_aw'(DELAY - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  // Contents are deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (en) begin
      r_mem[r_ptr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdf_r2_stage.sv
`default_nettype none
// ============================================================================
// Module      : sdf_r2_stage
// Description : Radix-2 SDF FFT stage: butterfly, twiddle rotation, 2-cycle out.
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_r2_stage
  import fft_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int DELAY   = 64,
  parameter int TW_FRAC = TW_FRAC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din_r,
  input  logic signed [DW-1:0] din_i,
  input  logic [1:0]           state,
  input  logic signed [DW-1:0] w_r,
  input  logic signed [DW-1:0] w_i,
  output logic                 out_valid,
  output logic signed [DW-1:0] dout_r,
  output logic signed [DW-1:0] dout_i
);

  localparam int c_pw = 2 * DW;

  op_e                  w_op;
  logic [c_pw-1:0]      w_h;
  logic [c_pw-1:0]      w_wr_data;
  logic signed [DW-1:0] w_h_r;
  logic signed [DW-1:0] w_h_i;
  logic signed [DW-1:0] w_sum_r;
  logic signed [DW-1:0] w_sum_i;
  logic signed [DW-1:0] w_dif_r;
  logic signed [DW-1:0] w_dif_i;

  assign w_op    = decode_state(state);
  assign w_h_r   = w_h[c_pw-1:DW];
  assign w_h_i   = w_h[DW-1:0];
  assign w_sum_r = w_h_r + din_r;
  assign w_sum_i = w_h_i + din_i;
  assign w_dif_r = w_h_r - din_r;
  assign w_dif_i = w_h_i - din_i;

  // Butterfly stores the difference for the following twiddle block.
  assign w_wr_data = (w_op == OP_BF) ? {w_dif_r, w_dif_i} : {din_r, din_i};

  sdf_delay_line #(
    .DELAY (DELAY),
    .WIDTH (c_pw)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (in_valid),
    .wr_data (w_wr_data),
    .rd_data (w_h)
  );

  // Full-width sign-extended operands so each product is formed at 2*DW.
  logic signed [c_pw-1:0] w_hr_x;
  logic signed [c_pw-1:0] w_hi_x;
  logic signed [c_pw-1:0] w_wr_x;
  logic signed [c_pw-1:0] w_wi_x;

  assign w_hr_x = {{DW{w_h_r[DW-1]}}, w_h_r};
  assign w_hi_x = {{DW{w_h_i[DW-1]}}, w_h_i};
  assign w_wr_x = {{DW{w_r[DW-1]}}, w_r};
  assign w_wi_x = {{DW{w_i[DW-1]}}, w_i};

  logic                   r_v1;
  logic                   r_rot1;
  logic signed [DW-1:0]   r_sum_r1;
  logic signed [DW-1:0]   r_sum_i1;
  logic signed [c_pw-1:0] r_p_rr;
  logic signed [c_pw-1:0] r_p_ii;
  logic signed [c_pw-1:0] r_p_ri;
  logic signed [c_pw-1:0] r_p_ir;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= in_valid && (w_op != OP_FILL);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      r_rot1   <= (w_op == OP_TW);
      r_sum_r1 <= w_sum_r;
      r_sum_i1 <= w_sum_i;
      r_p_rr   <= w_hr_x * w_wr_x;
      r_p_ii   <= w_hi_x * w_wi_x;
      r_p_ri   <= w_hr_x * w_wi_x;
      r_p_ir   <= w_hi_x * w_wr_x;
    end
  end

  logic signed [c_pw-1:0] w_re_full;
  logic signed [c_pw-1:0] w_im_full;

  assign w_re_full = r_p_rr - r_p_ii;
  assign w_im_full = r_p_ri + r_p_ir;

  // Taking bits above TW_FRAC is an arithmetic (floor) shift then truncation.
  logic w_unused;
  assign w_unused = ^{w_re_full[TW_FRAC-1:0], w_re_full[c_pw-1:TW_FRAC+DW],
                      w_im_full[TW_FRAC-1:0], w_im_full[c_pw-1:TW_FRAC+DW]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
      dout_i    <= '0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) begin
        dout_r <= r_rot1 ? w_re_full[TW_FRAC +: DW] : r_sum_r1;
        dout_i <= r_rot1 ? w_im_full[TW_FRAC +: DW] : r_sum_i1;
      end
    end
  end

endmodule
`default_nettype wire
